// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side timing checker for the colour-bar VGA
// generator. Measures line/frame timing from the sync pins and locks after
// two matching frames, reporting loss of lock.
// Optional macro FRAME_CRC_EN adds a CRC-16-CCITT signature of the six colour
// bits per frame; without it frame_crc is tied to 0.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   ena             clock enable; all state holds while low
//   vga_in          {R1,G1,B1,VS,R0,G0,B0,HS} from the generator
//   locked          timing stable
//   h_total/hs_width  clocks per line / hsync active clocks
//   v_total/vs_width  lines per frame / vsync active lines
//   frame_done      pulse on each vsync leading edge
//   err_pulse/err_cnt  loss-of-lock pulse and saturating count
//   frame_crc       colour signature of the last completed frame
module vga_timing_monitor #(
  parameter int unsigned HW       = 11,
  parameter int unsigned VW       = 10,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [7:0]    vga_in,
  output logic          locked,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] hs_width,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] vs_width,
  output logic          frame_done,
  output logic          err_pulse,
  output logic [7:0]    err_cnt,
  output logic [15:0]   frame_crc
);

  localparam logic [HW-1:0] H_MAX   = {HW{1'b1}};
  localparam logic [VW-1:0] V_MAX   = {VW{1'b1}};
  localparam logic [7:0]    IDLE_IN = SYNC_NEG ? 8'h11 : 8'h00;

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_VERIFY  = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic [7:0]    r_vga;
  logic          r_hs_d, r_vs_d;
  logic [HW-1:0] r_hcnt, r_h_total, r_hsw_cnt, r_hs_width, r_h_ref;
  logic [VW-1:0] r_vcnt, r_v_total, r_vsw_cnt, r_vs_width, r_v_ref;
  logic          r_frame_done, r_err_pulse, r_locked, r_exempt, r_vfail;
  logic [7:0]    r_err_cnt;
  logic [1:0]    r_state, w_state_nxt;
  logic          w_err;

  // Active-high sync views of the registered sample and their edges
  logic w_hs, w_vs, w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;
  assign w_hs       = r_vga[0] ^ SYNC_NEG;
  assign w_vs       = r_vga[4] ^ SYNC_NEG;
  assign w_hs_lead  = w_hs & ~r_hs_d;
  assign w_hs_trail = ~w_hs & r_hs_d;
  assign w_vs_lead  = w_vs & ~r_vs_d;
  assign w_vs_trail = ~w_vs & r_vs_d;

  // Period of the line that ends this cycle, timeout and mismatch checks
  logic [HW-1:0] w_period;
  logic          w_timeout, w_line_fail, w_v_mis;
  assign w_period    = r_hcnt + HW'(1);
  assign w_timeout   = (r_hcnt == H_MAX);
  assign w_v_mis     = (r_vcnt != r_v_ref);
  assign w_line_fail = ((r_state == S_VERIFY) || (r_state == S_LOCKED)) &&
                       ((w_hs_lead && !r_exempt && (w_period != r_h_ref)) || w_timeout);

  // Lock FSM next state; line check folds into the same decision as the
  // frame check so a coincident hs/vs failure yields a single error
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      S_SEARCH:  if (w_vs_lead) w_state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (w_timeout)      w_state_nxt = S_SEARCH;
        else if (w_vs_lead) w_state_nxt = S_VERIFY;
      end
      S_VERIFY: begin
        if (w_vs_lead)
          w_state_nxt = (w_line_fail || r_vfail || w_v_mis) ? S_SEARCH : S_LOCKED;
      end
      S_LOCKED: begin
        if (w_line_fail || (w_vs_lead && w_v_mis)) begin
          w_state_nxt = S_SEARCH;
          w_err       = 1'b1;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_SEARCH;
    else if (ena) r_state <= w_state_nxt;
  end

  // Input stage, counters, measurements and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga        <= IDLE_IN;
      r_hs_d       <= 1'b0;
      r_vs_d       <= 1'b0;
      r_hcnt       <= '0;
      r_h_total    <= '0;
      r_hsw_cnt    <= '0;
      r_hs_width   <= '0;
      r_h_ref      <= '0;
      r_vcnt       <= '0;
      r_v_total    <= '0;
      r_vsw_cnt    <= '0;
      r_vs_width   <= '0;
      r_v_ref      <= '0;
      r_frame_done <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
      r_locked     <= 1'b0;
      r_exempt     <= 1'b0;
      r_vfail      <= 1'b0;
    end else if (ena) begin
      r_vga  <= vga_in;
      r_hs_d <= w_hs;
      r_vs_d <= w_vs;

      if (w_hs_lead) begin
        r_hcnt    <= '0;
        r_h_total <= w_period;
      end else if (!w_timeout) begin
        r_hcnt <= w_period;
      end

      if (w_hs_lead)                         r_hsw_cnt <= HW'(1);
      else if (w_hs && (r_hsw_cnt != H_MAX)) r_hsw_cnt <= r_hsw_cnt + HW'(1);
      if (w_hs_trail)                        r_hs_width <= r_hsw_cnt;

      if (w_vs_lead) begin
        r_v_total <= r_vcnt;
        r_vcnt    <= w_hs_lead ? VW'(1) : '0;
      end else if (w_hs_lead && (r_vcnt != V_MAX)) begin
        r_vcnt <= r_vcnt + VW'(1);
      end

      if (w_vs_lead)                                     r_vsw_cnt <= w_hs_lead ? VW'(1) : '0;
      else if (w_vs && w_hs_lead && (r_vsw_cnt != V_MAX)) r_vsw_cnt <= r_vsw_cnt + VW'(1);
      if (w_vs_trail)                                    r_vs_width <= r_vsw_cnt;

      // References are taken from the frame measured in MEASURE
      if ((r_state == S_MEASURE) && (w_state_nxt == S_VERIFY)) begin
        r_h_ref <= r_h_total;
        r_v_ref <= r_vcnt;
      end

      // First line boundary inside VERIFY straddles the reference capture
      if ((r_state == S_MEASURE) && (w_state_nxt == S_VERIFY)) r_exempt <= 1'b1;
      else if (w_hs_lead)                                      r_exempt <= 1'b0;

      if (r_state != S_VERIFY) r_vfail <= 1'b0;
      else if (w_line_fail)    r_vfail <= 1'b1;

      r_frame_done <= w_vs_lead;
      r_err_pulse  <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      r_locked <= (w_state_nxt == S_LOCKED);
    end else begin
      r_frame_done <= 1'b0;
      r_err_pulse  <= 1'b0;
    end
  end

`ifdef FRAME_CRC_EN
  logic [5:0]  w_pix;
  logic [15:0] r_crc_acc, r_frame_crc;
  assign w_pix = {r_vga[7], r_vga[3], r_vga[6], r_vga[2], r_vga[5], r_vga[1]};

  function automatic logic [15:0] f_crc6(input logic [15:0] crc_in, input logic [5:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Per-frame colour signature; restarts on the vsync leading edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_acc   <= 16'hFFFF;
      r_frame_crc <= '0;
    end else if (ena) begin
      if (w_vs_lead) begin
        r_frame_crc <= r_crc_acc;
        r_crc_acc   <= f_crc6(16'hFFFF, w_pix);
      end else begin
        r_crc_acc <= f_crc6(r_crc_acc, w_pix);
      end
    end
  end
  assign frame_crc = r_frame_crc;
`else
  logic w_unused_colour;
  assign w_unused_colour = ^{r_vga[7:5], r_vga[3:1]};
  assign frame_crc = '0;
`endif

  assign locked     = r_locked;
  assign h_total    = r_h_total;
  assign hs_width   = r_hs_width;
  assign v_total    = r_v_total;
  assign vs_width   = r_vs_width;
  assign frame_done = r_frame_done;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down negative-sync
// raster (100 clocks x 20 lines, hsync 12 clocks, vsync 2 lines).
module tb_vga_timing_monitor;

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int H   = 100;
  localparam int HSW = 12;
  localparam int V   = 20;
  localparam int VSW = 2;

  logic          clk = 1'b0;
  logic          rst_n, ena;
  logic [7:0]    vga_in;
  logic          locked, frame_done, err_pulse;
  logic [HW-1:0] h_total, hs_width;
  logic [VW-1:0] v_total, vs_width;
  logic [7:0]    err_cnt;
  logic [15:0]   frame_crc;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int ep_cnt   = 0;
  int ep0;

  always #5 clk = ~clk;

  vga_timing_monitor #(.HW(HW), .VW(VW), .SYNC_NEG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vga_in(vga_in),
    .locked(locked), .h_total(h_total), .hs_width(hs_width),
    .v_total(v_total), .vs_width(vs_width), .frame_done(frame_done),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .frame_crc(frame_crc)
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (err_pulse)  ep_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Colour bars: 8 bars across the line, both intensity bits equal per colour
  function automatic logic [7:0] pix(input int x, input bit hs_a, input bit vs_a, input bit flip);
    logic [2:0] bar;
    logic [5:0] c;
    bar = 3'((x * 8) / H);
    c   = {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]};
    if (flip) c = ~c;
    return {c[5], c[3], c[1], ~vs_a, c[4], c[2], c[0], ~hs_a};
  endfunction

  task automatic send_lines(input int y0, input int y1, input int short_y, input int flip_y);
    for (int y = y0; y <= y1; y++) begin
      int len;
      len = (y == short_y) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        vga_in = pix(x, x < HSW, y < VSW, (y == flip_y) && (x == 50));
      end
    end
  endtask

  task automatic send_frame(input int nl, input int short_y, input int flip_y);
    send_lines(0, nl - 1, short_y, flip_y);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vga_in = 8'h11;
    end
  endtask

`ifdef FRAME_CRC_EN
  logic [15:0] m_acc, m_frame_crc, c_good;
  logic        m_vs_prev;

  function automatic logic [15:0] crc_ccitt6(input logic [15:0] s, input logic [5:0] d);
    logic [15:0] r;
    r = s;
    for (int i = 5; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ({16{r[15] ^ d[i]}} & 16'h1021);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc       <= 16'hFFFF;
      m_frame_crc <= 16'h0000;
      m_vs_prev   <= 1'b0;
    end else if (ena) begin
      logic [5:0] c;
      c = {vga_in[7], vga_in[3], vga_in[6], vga_in[2], vga_in[5], vga_in[1]};
      if (!vga_in[4] && !m_vs_prev) begin
        m_frame_crc <= m_acc;
        m_acc       <= crc_ccitt6(16'hFFFF, c);
      end else begin
        m_acc <= crc_ccitt6(m_acc, c);
      end
      m_vs_prev <= !vga_in[4];
    end
  end
`endif

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    vga_in = 8'h11;
    repeat (3) @(negedge clk);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_outputs", 32'(|{h_total, hs_width, v_total, vs_width, frame_done,
                                err_pulse, err_cnt, frame_crc}), 0);
    rst_n = 1'b1;

    // Initial lock: third vsync leading edge locks
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    chk("prelock_locked", 32'(locked), 0);
    send_frame(V, -1, -1);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_h_total", 32'(h_total), H);
    chk("lock_hs_width", 32'(hs_width), HSW);
    chk("lock_v_total", 32'(v_total), V);
    chk("lock_vs_width", 32'(vs_width), VSW);
    chk("lock_err_cnt", 32'(err_cnt), 0);
    chk("frame_done_count", 32'(fd_cnt), 3);

`ifdef FRAME_CRC_EN
    chk("crc_model_f2", 32'(frame_crc), 32'(m_frame_crc));
    c_good = frame_crc;
    send_frame(V, -1, -1);
    chk("crc_equal_f3", 32'(frame_crc), 32'(c_good));
    send_frame(V, -1, 5);
    send_frame(V, -1, -1);
    chk("crc_diff_flip", 32'(frame_crc != c_good), 1);
    chk("crc_model_flip", 32'(frame_crc), 32'(m_frame_crc));
    send_frame(V, -1, -1);
    chk("crc_restored", 32'(frame_crc), 32'(c_good));
    chk("crc_keep_lock", 32'(locked), 1);
`else
    chk("crc_disabled", 32'(frame_crc), 0);
`endif

    // One short line while locked
    ep0 = ep_cnt;
    send_frame(V, 7, -1);
    chk("short_locked", 32'(locked), 0);
    chk("short_err_cnt", 32'(err_cnt), 1);
    chk("short_err_pulses", 32'(ep_cnt - ep0), 1);
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    chk("short_relock_wait", 32'(locked), 0);
    send_frame(V, -1, -1);
    chk("short_relock", 32'(locked), 1);
    chk("short_single_pulse", 32'(ep_cnt - ep0), 1);

    // One frame with a missing line; detected at the following vsync edge
    ep0 = ep_cnt;
    send_frame(V - 1, -1, -1);
    chk("vshort_pending", 32'(locked), 1);
    send_frame(V, -1, -1);
    chk("vshort_locked", 32'(locked), 0);
    chk("vshort_v_total", 32'(v_total), V - 1);
    chk("vshort_err_cnt", 32'(err_cnt), 2);
    chk("vshort_err_pulses", 32'(ep_cnt - ep0), 1);
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    chk("vshort_relock", 32'(locked), 1);

    // Hsync stuck inactive: timeout after the line counter saturates
    ep0 = ep_cnt;
    send_lines(0, 4, -1, -1);
    idle(1900);
    chk("timeout_not_yet", 32'(locked), 1);
    idle(200);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_err_cnt", 32'(err_cnt), 3);
    chk("timeout_err_pulses", 32'(ep_cnt - ep0), 1);

    // Relock, then reset mid-frame
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    send_frame(V, -1, -1);
    chk("prereset_locked", 32'(locked), 1);
    send_lines(0, 9, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_locked", 32'(locked), 0);
    chk("async_reset_outputs", 32'(|{h_total, hs_width, v_total, vs_width, frame_done,
                                     err_pulse, err_cnt, frame_crc}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_lines(10, V - 1, -1, -1);
    send_frame(V, -1, -1);
    chk("postreset_one_frame", 32'(locked), 0);
    send_frame(V, -1, -1);
    chk("postreset_two_frames", 32'(locked), 0);
    send_frame(V, -1, -1);
    chk("postreset_locked", 32'(locked), 1);
    chk("postreset_err_cnt", 32'(err_cnt), 0);
    chk("postreset_h_total", 32'(h_total), H);
    chk("postreset_v_total", 32'(v_total), V);

    // Enable low: junk on the pins must not disturb anything
    ena = 1'b0;
    idle(50);
    send_lines(0, 2, 1, -1);
    chk("hold_locked", 32'(locked), 1);
    chk("hold_h_total", 32'(h_total), H);
    chk("hold_v_total", 32'(v_total), V);
    chk("hold_err_cnt", 32'(err_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
